// File: rtl/apu_dispatcher.sv
// apu_dispatcher: core-side initiator of the APU request/response interface.
// Vector instructions from the scalar pipeline go into a small circular FIFO.
// They are issued one at a time on apu_req/apu_gnt, and each completion is
// awaited on apu_rvalid. Instructions that return a scalar value produce a
// registered write-back pulse. Only one instruction is outstanding at a time,
// so completions are in order.
//
// Ports:
//   clk, n_reset             clock, async active-low reset
//   instr_valid_i/ready_o    pipeline push handshake (ready = FIFO not full)
//   instr_i, rs1_i, rs2_i    instruction word and scalar operands
//   rd_addr_i, rd_write_i    scalar destination, returns-result flag
//   apu_req/apu_gnt          request handshake to the accelerator
//   apu_operands/op/flags_o  head entry payload, zero while not requesting
//   apu_rvalid/apu_result    completion pulse and scalar result
//   wb_valid_o/addr_o/data_o scalar register-file write-back
//   busy_o                   work queued or in flight
//   timeout_o, err_o         abandoned instruction / stray response pulses
module apu_dispatcher #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic             instr_valid_i,
  output logic             instr_ready_o,
  input  logic [31:0]      instr_i,
  input  logic [31:0]      rs1_i,
  input  logic [31:0]      rs2_i,
  input  logic [4:0]       rd_addr_i,
  input  logic             rd_write_i,
  output logic             apu_req,
  input  logic             apu_gnt,
  output logic [2:0][31:0] apu_operands,
  output logic [5:0]       apu_op,
  output logic [14:0]      apu_flags_o,
  input  logic             apu_rvalid,
  input  logic [31:0]      apu_result,
  output logic             wb_valid_o,
  output logic [4:0]       wb_addr_o,
  output logic [31:0]      wb_data_o,
  output logic             busy_o,
  output logic             timeout_o,
  output logic             err_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  // Counter only has to reach TIMEOUT_CYCLES-1.
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [TW-1:0] TO_LAST = TO_EN ? TW'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [4:0]  rd_addr;
    logic        rd_write;
  } entry_t;

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t          state_q, state_d;
  entry_t          mem_q [FIFO_DEPTH];
  entry_t          head;
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q, count_d;
  logic [TW-1:0]   tcnt_q;
  logic [4:0]      out_rd_q;
  logic            out_rw_q;
  logic            wb_valid_q, timeout_q, err_q;
  logic [4:0]      wb_addr_q;
  logic [31:0]     wb_data_q;
  logic            push, pop, to_hit, in_resp;

  assign head          = mem_q[rd_ptr_q];
  assign instr_ready_o = (count_q != FULL_CNT);
  assign push          = instr_valid_i & instr_ready_o;
  assign pop           = (state_q == REQ) & apu_gnt;
  assign in_resp       = (state_q == RESP);
  assign to_hit        = TO_EN & in_resp & !apu_rvalid & (tcnt_q == TO_LAST);

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (count_q != '0) state_d = REQ;
      REQ:     if (apu_gnt) state_d = RESP;
      RESP:    if (apu_rvalid || to_hit) state_d = (count_d != '0) ? REQ : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Payload storage carries no reset; outputs are gated by apu_req.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{instr_i, rs1_i, rs2_i, rd_addr_i, rd_write_i};
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      tcnt_q     <= '0;
      out_rd_q   <= '0;
      out_rw_q   <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
      timeout_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
        out_rd_q <= head.rd_addr;
        out_rw_q <= head.rd_write;
        tcnt_q   <= '0;
      end else if (in_resp) begin
        tcnt_q <= tcnt_q + TW'(1);
      end
      wb_valid_q <= in_resp & apu_rvalid & out_rw_q;
      if (in_resp & apu_rvalid & out_rw_q) begin
        wb_addr_q <= out_rd_q;
        wb_data_q <= apu_result;
      end
      timeout_q <= to_hit;
      err_q     <= apu_rvalid & !in_resp;
    end
  end

  assign apu_req      = (state_q == REQ);
  assign apu_operands = apu_req ? {head.instr, head.rs2, head.rs1} : '0;
  assign apu_op       = apu_req ? head.instr[31:26] : '0;
  assign apu_flags_o  = apu_req ? {9'b0, head.rd_write, head.rd_addr} : '0;

  assign wb_valid_o = wb_valid_q;
  assign wb_addr_o  = wb_addr_q;
  assign wb_data_o  = wb_data_q;
  assign timeout_o  = timeout_q;
  assign err_o      = err_q;
  assign busy_o     = (count_q != '0) || (state_q != IDLE);

endmodule

// File: tb/tb_apu_dispatcher.sv
// Directed bench for apu_dispatcher (FIFO_DEPTH=4, TIMEOUT_CYCLES=8).
module tb_apu_dispatcher;
  logic             clk = 1'b0;
  logic             n_reset = 1'b0;
  logic             instr_valid_i = 1'b0;
  logic             instr_ready_o;
  logic [31:0]      instr_i = '0, rs1_i = '0, rs2_i = '0;
  logic [4:0]       rd_addr_i = '0;
  logic             rd_write_i = 1'b0;
  logic             apu_req;
  logic             apu_gnt = 1'b0;
  logic [2:0][31:0] apu_operands;
  logic [5:0]       apu_op;
  logic [14:0]      apu_flags_o;
  logic             apu_rvalid = 1'b0;
  logic [31:0]      apu_result = '0;
  logic             wb_valid_o;
  logic [4:0]       wb_addr_o;
  logic [31:0]      wb_data_o;
  logic             busy_o, timeout_o, err_o;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] t_ins [5];
  logic [31:0] t_rs1 [5];
  logic [31:0] t_rs2 [5];
  logic [4:0]  t_rd  [5];
  logic        t_rw  [5];

  apu_dispatcher #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .n_reset(n_reset),
    .instr_valid_i(instr_valid_i), .instr_ready_o(instr_ready_o),
    .instr_i(instr_i), .rs1_i(rs1_i), .rs2_i(rs2_i),
    .rd_addr_i(rd_addr_i), .rd_write_i(rd_write_i),
    .apu_req(apu_req), .apu_gnt(apu_gnt), .apu_operands(apu_operands),
    .apu_op(apu_op), .apu_flags_o(apu_flags_o),
    .apu_rvalid(apu_rvalid), .apu_result(apu_result),
    .wb_valid_o(wb_valid_o), .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o),
    .busy_o(busy_o), .timeout_o(timeout_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] r1,
                       input logic [31:0] r2, input logic [4:0] rd, input logic rw);
    instr_valid_i = v;
    instr_i       = ins;
    rs1_i         = r1;
    rs2_i         = r2;
    rd_addr_i     = rd;
    rd_write_i    = rw;
  endtask

  task automatic drive_tbl(input int k);
    drive(1'b1, t_ins[k], t_rs1[k], t_rs2[k], t_rd[k], t_rw[k]);
  endtask

  task automatic chk_head(input string tag, input int k);
    chk({tag, "_ops"}, 128'(apu_operands), 128'({t_ins[k], t_rs2[k], t_rs1[k]}));
    chk({tag, "_op"}, 128'(apu_op), 128'(t_ins[k][31:26]));
    chk({tag, "_flags"}, 128'(apu_flags_o), 128'({9'b0, t_rw[k], t_rd[k]}));
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_req"}, 128'(apu_req), 128'(0));
    chk({tag, "_ops"}, 128'(apu_operands), 128'(0));
    chk({tag, "_op"}, 128'(apu_op), 128'(0));
    chk({tag, "_flags"}, 128'(apu_flags_o), 128'(0));
    chk({tag, "_wbv"}, 128'(wb_valid_o), 128'(0));
    chk({tag, "_wba"}, 128'(wb_addr_o), 128'(0));
    chk({tag, "_wbd"}, 128'(wb_data_o), 128'(0));
    chk({tag, "_to"}, 128'(timeout_o), 128'(0));
    chk({tag, "_err"}, 128'(err_o), 128'(0));
    chk({tag, "_busy"}, 128'(busy_o), 128'(0));
    chk({tag, "_rdy"}, 128'(instr_ready_o), 128'(1));
  endtask

  initial begin
    for (int i = 0; i < 5; i++) begin
      t_ins[i] = {6'(i + 9), 26'(i + 256)};
      t_rs1[i] = 32'hA000_0000 + 32'(i);
      t_rs2[i] = 32'hB000_0000 + 32'(i);
      t_rd[i]  = 5'(i + 1);
      t_rw[i]  = 1'b0;
    end

    // Reset state
    #3;
    chk_reset_outs("rst");
    step();
    n_reset = 1'b1;
    step();

    // Single vsetvli, immediate grant, result one cycle into RESP
    drive(1'b1, 32'hC000_7057, 32'h11, 32'h22, 5'd5, 1'b1);
    step();
    drive(1'b0, '0, '0, '0, '0, 1'b0);
    chk("t1_req_e0", 128'(apu_req), 128'(0));
    chk("t1_busy", 128'(busy_o), 128'(1));
    step();
    chk("t1_req_e1", 128'(apu_req), 128'(1));
    chk("t1_ops", 128'(apu_operands), 128'({32'hC000_7057, 32'h22, 32'h11}));
    chk("t1_op", 128'(apu_op), 128'(6'h30));
    chk("t1_flags", 128'(apu_flags_o), 128'(15'h25));
    apu_gnt = 1'b1;
    step();
    apu_gnt = 1'b0;
    chk("t1_req_resp", 128'(apu_req), 128'(0));
    apu_rvalid = 1'b1;
    apu_result = 32'h10;
    step();
    apu_rvalid = 1'b0;
    chk("t1_wbv", 128'(wb_valid_o), 128'(1));
    chk("t1_wba", 128'(wb_addr_o), 128'(5));
    chk("t1_wbd", 128'(wb_data_o), 128'(32'h10));
    step();
    chk("t1_wbv_end", 128'(wb_valid_o), 128'(0));
    chk("t1_busy_end", 128'(busy_o), 128'(0));
    chk("t1_wbd_hold", 128'(wb_data_o), 128'(32'h10));

    // Fill to full with gnt low, then drain in order
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t2_rdy%0d", i), 128'(instr_ready_o), 128'(1));
      drive_tbl(i);
      step();
    end
    drive_tbl(4);
    chk("t2_full", 128'(instr_ready_o), 128'(0));
    chk("t2_req0", 128'(apu_req), 128'(1));
    chk_head("t2_h0", 0);
    apu_gnt = 1'b1;
    step();
    apu_gnt = 1'b0;
    chk("t2_req_resp0", 128'(apu_req), 128'(0));
    chk("t2_rdy_after_pop", 128'(instr_ready_o), 128'(1));
    apu_rvalid = 1'b1;
    step();
    apu_rvalid = 1'b0;
    drive(1'b0, '0, '0, '0, '0, 1'b0);
    chk("t2_nowb0", 128'(wb_valid_o), 128'(0));
    for (int k = 1; k < 5; k++) begin
      chk($sformatf("t2_req%0d", k), 128'(apu_req), 128'(1));
      chk_head($sformatf("t2_h%0d", k), k);
      apu_gnt = 1'b1;
      step();
      apu_gnt = 1'b0;
      chk($sformatf("t2_resp%0d", k), 128'(apu_req), 128'(0));
      apu_rvalid = 1'b1;
      step();
      apu_rvalid = 1'b0;
      chk($sformatf("t2_nowb%0d", k), 128'(wb_valid_o), 128'(0));
    end
    chk("t2_idle_req", 128'(apu_req), 128'(0));
    chk("t2_idle_busy", 128'(busy_o), 128'(0));

    // vadd (no result) then vmv.x.s to x7
    drive(1'b1, 32'h0231_00D7, 32'h1, 32'h2, 5'd3, 1'b0);
    step();
    drive(1'b1, 32'h4200_2357, 32'h3, 32'h4, 5'd7, 1'b1);
    step();
    drive(1'b0, '0, '0, '0, '0, 1'b0);
    chk("t3_req_vadd", 128'(apu_req), 128'(1));
    chk("t3_op_vadd", 128'(apu_op), 128'(6'h00));
    apu_gnt = 1'b1;
    step();
    apu_gnt = 1'b0;
    apu_rvalid = 1'b1;
    apu_result = 32'h1234_5678;
    step();
    apu_rvalid = 1'b0;
    chk("t3_nowb_vadd", 128'(wb_valid_o), 128'(0));
    chk("t3_req_vmv", 128'(apu_req), 128'(1));
    chk("t3_op_vmv", 128'(apu_op), 128'(6'h10));
    chk("t3_flags_vmv", 128'(apu_flags_o), 128'(15'h27));
    apu_gnt = 1'b1;
    step();
    apu_gnt = 1'b0;
    apu_rvalid = 1'b1;
    apu_result = 32'hDEAD_BEEF;
    step();
    apu_rvalid = 1'b0;
    chk("t3_wbv", 128'(wb_valid_o), 128'(1));
    chk("t3_wba", 128'(wb_addr_o), 128'(7));
    chk("t3_wbd", 128'(wb_data_o), 128'(32'hDEAD_BEEF));
    step();
    chk("t3_wbv_once", 128'(wb_valid_o), 128'(0));

    // Timeout after 8 RESP cycles, then a late response
    drive(1'b1, 32'hC400_0057, 32'h5, 32'h6, 5'd3, 1'b1);
    step();
    drive(1'b1, 32'h0800_0057, 32'h7, 32'h8, 5'd4, 1'b0);
    step();
    drive(1'b0, '0, '0, '0, '0, 1'b0);
    chk("t4_req_a", 128'(apu_req), 128'(1));
    apu_gnt = 1'b1;
    step();
    apu_gnt = 1'b0;
    for (int c = 1; c < 8; c++) begin
      chk($sformatf("t4_wait%0d", c), 128'({timeout_o, apu_req}), 128'(0));
      step();
    end
    step();
    chk("t4_to", 128'(timeout_o), 128'(1));
    chk("t4_nowb", 128'(wb_valid_o), 128'(0));
    chk("t4_req_b", 128'(apu_req), 128'(1));
    chk("t4_op_b", 128'(apu_op), 128'(6'h02));
    apu_rvalid = 1'b1;
    step();
    apu_rvalid = 1'b0;
    chk("t4_to_pulse", 128'(timeout_o), 128'(0));
    chk("t4_late_err", 128'(err_o), 128'(1));
    chk("t4_late_nowb", 128'(wb_valid_o), 128'(0));
    chk("t4_still_req", 128'(apu_req), 128'(1));
    step();
    chk("t4_err_pulse", 128'(err_o), 128'(0));
    apu_gnt = 1'b1;
    step();
    apu_gnt = 1'b0;
    apu_rvalid = 1'b1;
    step();
    apu_rvalid = 1'b0;
    chk("t4_done", 128'({busy_o, wb_valid_o}), 128'(0));

    // Stray response in IDLE
    apu_rvalid = 1'b1;
    step();
    apu_rvalid = 1'b0;
    chk("t5_err", 128'(err_o), 128'(1));
    chk("t5_busy", 128'(busy_o), 128'(0));
    chk("t5_rdy", 128'(instr_ready_o), 128'(1));
    step();
    chk("t5_req", 128'(apu_req), 128'(0));
    chk("t5_err_end", 128'(err_o), 128'(0));

    // Reset while in RESP with 3 entries queued
    for (int i = 0; i < 4; i++) begin
      t_rw[i] = 1'b1;
      drive_tbl(i);
      step();
    end
    drive(1'b0, '0, '0, '0, '0, 1'b0);
    chk("t6_req", 128'(apu_req), 128'(1));
    apu_gnt = 1'b1;
    step();
    apu_gnt = 1'b0;
    chk("t6_full_minus1", 128'(instr_ready_o), 128'(1));
    #2;
    n_reset = 1'b0;
    #1;
    chk_reset_outs("t6_rst");
    step();
    n_reset = 1'b1;
    step();
    chk("t6_post_busy", 128'(busy_o), 128'(0));
    apu_rvalid = 1'b1;
    apu_result = 32'h5555_AAAA;
    step();
    apu_rvalid = 1'b0;
    chk("t6_err", 128'(err_o), 128'(1));
    chk("t6_nowb", 128'(wb_valid_o), 128'(0));
    chk("t6_wbd", 128'(wb_data_o), 128'(0));
    step();
    chk("t6_idle", 128'({busy_o, apu_req}), 128'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/apu_dispatcher.md
# apu_dispatcher

Core-side initiator of the APU interface that feeds the vector accelerator. It buffers vector instructions from the scalar pipeline in a small FIFO and presents them one at a time on apu_req/apu_gnt. It waits for each completion on apu_rvalid and, for instructions that return a scalar value (vsetvli, vmv.x.s), issues a registered write-back to the scalar register file. One instruction is outstanding at a time, and instructions complete in order.

## Interface
- FIFO_DEPTH, 4: instruction buffer entries; power of two, ≥2.
- TIMEOUT_CYCLES, 255: maximum cycles in RESP before abandoning the instruction; 0 disables the timeout.
- clk  in  1  clock.
- n_reset  in  1  reset, asynchronous, active-low.
- instr_valid_i  in  1  pipeline offers an instruction.
- instr_ready_o  out  1  FIFO not full; push when valid & ready.
- instr_i  in  32  vector instruction word.
- rs1_i, rs2_i  in  32 each  scalar operand values.
- rd_addr_i  in  5  scalar destination register.
- rd_write_i  in  1  instruction returns a scalar result.
- apu_req  out  1  request to accelerator.
- apu_gnt  in  1  accelerator accepts the request.
- apu_operands  out  32 x [2:0]  [0]=rs1, [1]=rs2, [2]=instruction word.
- apu_op  out  6  instr[31:26] (funct6).
- apu_flags_o  out  15  {9'b0, rd_write, rd_addr}.
- apu_rvalid  in  1  completion pulse from accelerator.
- apu_result  in  32  scalar result, valid with apu_rvalid.
- wb_valid_o  out  1  one-cycle write-back pulse.
- wb_addr_o  out  5  write-back register.
- wb_data_o  out  32  write-back data.
- busy_o  out  1  FIFO non-empty or state ≠ IDLE.
- timeout_o  out  1  one-cycle pulse when an instruction is abandoned.
- err_o  out  1  one-cycle pulse on a protocol violation.

## Operation
- FIFO entry: {instr, rs1, rs2, rd_addr, rd_write}, 102 bits. Circular read/write pointers plus a count of width clog2(FIFO_DEPTH)+1; pointers wrap at FIFO_DEPTH.
- instr_ready_o = !full. It depends only on the registered count, so there is no same-cycle push-when-full even if a pop occurs.
- FSM states and transitions:
  - IDLE→REQ when count≠0.
  - REQ→RESP on apu_gnt; the head entry is popped on this edge.
  - RESP→REQ on apu_rvalid if count≠0 after any simultaneous push; otherwise RESP→IDLE.
  - RESP→REQ/IDLE on timeout, same rule.
- apu_req = (state==REQ). apu_operands, apu_op and apu_flags_o come from the FIFO head while apu_req=1 and are all-zero otherwise. They stay stable in REQ until gnt.
- On the gnt edge, rd_addr and rd_write are latched into the outstanding register, and the timeout counter is cleared.
- In RESP, the counter increments each cycle. If TIMEOUT_CYCLES≠0 and the counter equals TIMEOUT_CYCLES-1 without apu_rvalid:
  - timeout_o pulses the next cycle;
  - no write-back occurs;
  - the instruction is dropped.
- apu_rvalid in RESP with latched rd_write=1: on the next cycle wb_valid_o=1, wb_addr_o=latched rd_addr, wb_data_o=apu_result. With rd_write=0 there is no wb pulse.
- apu_rvalid outside RESP (IDLE or REQ, including a late response after a timeout) is ignored and pulses err_o the next cycle.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- A push into an empty FIFO while in IDLE is visible to the FSM on the following cycle.
- Reset mid-operation: the FIFO is emptied, the FSM returns to IDLE, and any outstanding instruction is discarded with no write-back.

## Timing
- Reset values:
  - apu_req=0, apu_operands=0, apu_op=0, apu_flags_o=0;
  - wb_valid_o=0, wb_addr_o=0, wb_data_o=0;
  - timeout_o=0, err_o=0, busy_o=0;
  - instr_ready_o=1.
- Push-to-request latency: push at edge E0 into an empty FIFO in IDLE gives apu_req high in the cycle after E1.
- gnt-to-RESP: 1 edge.
- rvalid-to-wb_valid_o: 1 cycle, registered.
- Back-to-back: with rvalid at edge En and the FIFO non-empty, apu_req is high in the cycle after En. Minimum 1 cycle between rvalid and the next apu_req.
- wb_valid_o, timeout_o and err_o are single-cycle pulses. wb_addr_o and wb_data_o hold their values until the next write-back.

## Test plan
- Single vsetvli (rd_write=1, rd_addr=5), accelerator grants immediately and returns apu_result=0x10 after 1 cycle → apu_req high 2 cycles after push, one wb pulse with addr 5 and data 0x10, busy_o falls after the wb cycle.
- Push 5 instructions back-to-back with FIFO_DEPTH=4 while gnt is held low → instr_ready_o drops after 4 pushes. Raise gnt → instructions issue in push order with operands matching each entry, and each apu_req starts the cycle after the prior rvalid.
- vadd (rd_write=0) completes with rvalid → no wb pulse. A vmv.x.s that follows returns 0xDEADBEEF to rd 7 → exactly one wb pulse.
- TIMEOUT_CYCLES=8, rvalid withheld → timeout_o pulses after 8 RESP cycles and the FSM proceeds to the next entry. A late rvalid then → err_o pulse with no wb.
- apu_rvalid asserted while in IDLE → err_o pulse, FIFO and FSM unchanged.
- n_reset asserted while in RESP with 3 entries queued → all outputs at reset values, count=0. A subsequent rvalid → err_o only.
